// File: rtl/remainder_reconstructor.sv
// Shift-add multiply-accumulate: product = multiplicand * multiplier + addend, with overflow flag.
// Processes one multiplier bit per clock and stops as soon as the remaining multiplier bits are zero.
module remainder_reconstructor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic [31:0] addend,
    output logic [31:0] product,
    output logic        overflow,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mult;
    logic [31:0] r_product;
    logic        r_overflow;
    logic        r_busy;
    logic        r_done;

    logic [63:0] w_acc_next;

    // The 64-bit accumulator tops out at 2^64 - 2^32, so this sum never wraps.
    assign w_acc_next = r_mult[0] ? (r_acc + r_mcand) : r_acc;

    // Handshake: start is sampled only in IDLE and is never queued; done is a
    // one-cycle pulse, and product/overflow stay stable from done until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= 64'd0;
            r_mcand    <= 64'd0;
            r_mult     <= 32'd0;
            r_product  <= 32'd0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (multiplier != 32'd0) begin
                            r_acc   <= {32'd0, addend};
                            r_mcand <= {32'd0, multiplicand};
                            r_mult  <= multiplier;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end else begin
                            r_product  <= addend;
                            r_overflow <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    if (r_mult != 32'd0) begin
                        r_acc   <= w_acc_next;
                        r_mcand <= {r_mcand[62:0], 1'b0};
                        r_mult  <= {1'b0, r_mult[31:1]};
                    end else begin
                        r_product  <= r_acc[31:0];
                        r_overflow <= |r_acc[63:32];
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign product   = r_product;
    assign overflow  = r_overflow;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_remainder_reconstructor.sv
// Bench for remainder_reconstructor: a vector table of results, latencies and busy lengths,
// followed by hand-written sequences for held start and reset during a calculation.
module tb_remainder_reconstructor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] c = 32'd0;
    logic [31:0] product;
    logic        overflow;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_prod;
        logic        exp_ovf;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t        vecs [12];
    logic [32:0] exp_q [$];
    logic [32:0] mon_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [31:0] prev_prod = 32'd0;
    logic        prev_ovf  = 1'b0;

    remainder_reconstructor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .addend       (c),
        .product      (product),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] mc);
        logic [63:0] r;
        r = 64'(ma) * 64'(mb) + 64'(mc);
        return {|r[63:32], r[31:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] mb);
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
        return (mb == 32'd0) ? 1 : k + 2;
    endfunction

    // Scoreboard: every done pulse pops one expected {overflow, product}.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with product=%0h, expected no done", product);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {31'd0, overflow, product}, {31'd0, mon_exp});
            end
        end
    end

    task automatic do_op(input vec_t v, input string name);
        int lat;
        int busy_n;
        bit hold_ok;
        @(negedge clk);
        start = 1'b1;
        a = v.a;
        b = v.b;
        c = v.c;
        exp_q.push_back({v.exp_ovf, v.exp_prod});
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        lat = 1;
        busy_n = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            if (product !== prev_prod || overflow !== prev_ovf) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(v.exp_busy));
        check({name, "_hold_during_calc"}, 64'(hold_ok), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        prev_prod = v.exp_prod;
        prev_ovf  = v.exp_ovf;
        @(posedge clk);
        #1;
        check({name, "_done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int d0;
        logic [32:0] r;
        vec_t v;

        vecs[0] = '{32'd17,         32'd5,          32'd2,          32'd87,  1'b0, 5,  4};
        vecs[1] = '{32'hDEADBEEF,   32'd0,          32'd9,          32'd9,   1'b0, 1,  0};
        vecs[2] = '{32'h0001_0000,  32'h0001_0000,  32'd0,          32'd0,   1'b1, 19, 18};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,   1'b1, 34, 33};
        vecs[4] = '{32'd5,          32'd1,          32'd3,          32'd8,   1'b0, 3,  2};
        vecs[5] = '{32'd0,          32'h0000_FFFF,  32'd7,          32'd7,   1'b0, 18, 17};
        for (int i = 6; i < 12; i++) begin
            vecs[i].a = $urandom;
            vecs[i].b = $urandom >> $urandom_range(0, 31);
            vecs[i].c = $urandom;
            r = model(vecs[i].a, vecs[i].b, vecs[i].c);
            vecs[i].exp_prod = r[31:0];
            vecs[i].exp_ovf  = r[32];
            vecs[i].exp_lat  = model_lat(vecs[i].b);
            vecs[i].exp_busy = (vecs[i].b == 32'd0) ? 0 : vecs[i].exp_lat - 1;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_product", 64'(product), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // Held start: operand changes during CALC are ignored, restart happens only from IDLE.
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        a = 32'd3;
        b = 32'h8000_0000;
        c = 32'd1;
        exp_q.push_back({1'b1, 32'h8000_0001});
        @(posedge clk);
        #1;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            a = $urandom;
            b = $urandom | 32'd1;
            c = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_latency", 64'(lat), 64'd34);
        a = 32'd2;
        b = 32'd3;
        c = 32'd4;
        exp_q.push_back({1'b0, 32'd10});
        @(posedge clk);
        #1;
        check("held_done_width", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("held_restart_busy", 64'(busy), 64'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("held_restart_latency", 64'(lat), 64'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_done_count", 64'(done_cnt - d0), 64'd2);
        prev_prod = 32'd10;
        prev_ovf  = 1'b0;

        // Reset in the middle of a long calculation: no done, outputs cleared at once.
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        a = 32'h1234_5678;
        b = 32'hFFFF_FFFF;
        c = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_product", 64'(product), 64'd0);
        check("midreset_overflow", 64'(overflow), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        prev_prod = 32'd0;
        prev_ovf  = 1'b0;

        v = '{32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 5, 4};
        do_op(v, "after_reset");

        repeat (2) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/remainder_reconstructor.md
# remainder_reconstructor

Sequential shift-add multiply-accumulate unit computing `product = multiplicand * multiplier + addend` with overflow detection. It is the inverse companion of the team's repeated-subtraction modulo divider: given divisor, quotient and remainder, it rebuilds the dividend so results can be cross-checked on-chip. It uses the same start/done handshake style, processes one multiplier bit per clock, and terminates early once the remaining multiplier bits are zero.

## Interface
Parameters:
- none (datapath fixed at 32 bits)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `multiplicand`  in  32  unsigned operand A (e.g. divisor)
- `multiplier`  in  32  unsigned operand B (e.g. quotient); sets iteration count
- `addend`  in  32  unsigned value added to A*B (e.g. remainder)
- `product`  out  32  low 32 bits of A*B+C; registered
- `overflow`  out  1  high when A*B+C ≥ 2^32; registered with `product`
- `busy`  out  1  high while in CALC
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start`=1 with `multiplier`≠0: latch operands; set acc (64-bit) = zero-extended `addend`, mcand_reg (64-bit) = zero-extended `multiplicand`, mult_reg = `multiplier`; go to CALC, `busy`<=1.
  - `start`=1 with `multiplier`=0: `product`<=`addend`, `overflow`<=0, `done`<=1; go to DONE.
  - `start`=0: stay; `done`<=0.
- CALC, per cycle:
  - if mult_reg≠0: if mult_reg[0], acc <= acc + mcand_reg; mcand_reg <<= 1; mult_reg >>= 1.
  - if mult_reg=0: `product`<=acc[31:0], `overflow`<=|acc[63:32], `busy`<=0, `done`<=1; go to DONE.
- DONE: `done`<=0; go to IDLE.
- Arithmetic:
  - All arithmetic is unsigned.
  - The 64-bit acc cannot wrap, since the maximum result is (2^32−1)^2 + (2^32−1) = 2^64 − 2^32.
- Handshake and input rules:
  - Operand inputs are don't-care except at the accepting edge.
  - `start` is ignored in CALC and DONE. It is not queued.
  - `product`/`overflow` hold their value from the done pulse until the next completion. They do not change while CALC is running.

## Timing
- Reset (async, `rst_n`=0): state=IDLE; `product`=0, `overflow`=0, `busy`=0, `done`=0; internal registers cleared. Reset mid-CALC aborts with no `done` pulse; outputs read 0.
- Let k = bit length of `multiplier` (index of highest set bit + 1).
- Start accepted at edge T, `multiplier`≠0:
  - CALC from T.
  - Steps at T+1..T+k.
  - Terminating check at T+k+1: `done`=1 for the cycle after T+k+1.
  - Latency is k+2 edges: best case 3 (`multiplier`=1), worst case 34 (bit 31 set).
- `multiplier`=0: `done`=1 for the cycle after T (latency 1).
- DONE always lasts exactly one cycle. A new `start` is accepted on the first edge where state is IDLE, which is the edge after `done` deasserts. Back-to-back throughput is latency + 1 cycles.
- `start` held continuously restarts immediately in each IDLE cycle.

## Test plan
- A=17, B=5, C=2, pulse `start` -> `done` pulses 5 edges after acceptance; `product`=87, `overflow`=0, `busy` high for exactly 4 cycles.
- B=0, A=0xDEADBEEF, C=9 -> `done` 1 edge after acceptance; `product`=9, `overflow`=0, `busy` never high.
- A=0x00010000, B=0x00010000, C=0 -> `product`=0, `overflow`=1; latency 19 edges.
- A=B=C=0xFFFFFFFF -> `product`=0x00000000, `overflow`=1; latency 34 edges.
- Hold `start`=1 with changing operands during CALC of A=3, B=0x80000000, C=1 -> operands ignored; `product`=0x80000001, `overflow`=1; one `done` per accepted start.
- Deassert `rst_n` during CALC (cycle 10 of 34) -> all outputs 0 asynchronously, no `done`. After release, A=6, B=7, C=0 yields `product`=42.
